// File: rtl/vend_payout_ctrl.sv
// rtl/vend_payout_ctrl.sv - vending payout sequencer: queued vend pulse plus acked quarter ejection
module vend_payout_ctrl #(
    parameter int PULSE_CYC   = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       dispense,
    input  logic [1:0] change,
    input  logic       eject_ack,
    output logic       vend_motor,
    output logic       coin_eject,
    output logic       busy,
    output logic       queue_full,
    output logic       overflow,
    output logic       fault
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int TM1  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TMAX = (TM1 > TIMEOUT_CYC) ? TM1 : TIMEOUT_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_GAP,
        S_EJECT,
        S_WAIT_ACK,
        S_FAULT
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [1:0]      coins_left, coins_nxt;
    logic            ack_seen, ack_nxt;

    logic [1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_nxt;
    logic            fifo_full, pop, push, drop;
    logic [1:0]      head;

    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign pop       = (state == S_IDLE) && (count != '0);
    // A pop frees a slot on the same edge, so a full FIFO can still accept a push.
    assign push      = dispense && (!fifo_full || pop);
    assign drop      = dispense && fifo_full && !pop;
    assign head      = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        coins_nxt = coins_left;
        ack_nxt   = ack_seen;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = S_VEND;
                    timer_nxt = TW'(PULSE_CYC);
                    coins_nxt = head;
                end
            end
            S_VEND: begin
                if (timer <= TW'(1)) begin
                    state_nxt = S_GAP;
                    timer_nxt = TW'(GAP_CYC);
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_GAP: begin
                if (timer <= TW'(1)) begin
                    if (coins_left != 2'd0) begin
                        state_nxt = S_EJECT;
                        timer_nxt = TW'(PULSE_CYC);
                        ack_nxt   = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                        timer_nxt = '0;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_EJECT: begin
                if (eject_ack)
                    ack_nxt = 1'b1;
                if (timer <= TW'(1)) begin
                    ack_nxt = 1'b0;
                    // An ack arriving on the final pulse cycle still counts as inside the pulse.
                    if (ack_seen || eject_ack) begin
                        if (coins_left != 2'd0)
                            coins_nxt = coins_left - 2'd1;
                        state_nxt = S_GAP;
                        timer_nxt = TW'(GAP_CYC);
                    end else begin
                        state_nxt = S_WAIT_ACK;
                        timer_nxt = TW'(TIMEOUT_CYC);
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (eject_ack) begin
                    if (coins_left != 2'd0)
                        coins_nxt = coins_left - 2'd1;
                    state_nxt = S_GAP;
                    timer_nxt = TW'(GAP_CYC);
                end else if (timer <= TW'(1)) begin
                    state_nxt = S_FAULT;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= change;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            coins_left <= 2'd0;
            ack_seen   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            vend_motor <= 1'b0;
            coin_eject <= 1'b0;
            busy       <= 1'b0;
            queue_full <= 1'b0;
            overflow   <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            coins_left <= coins_nxt;
            ack_seen   <= ack_nxt;
            count      <= count_nxt;
            if (push)
                wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            // Drives follow the state being entered; busy reflects the state being left.
            vend_motor <= (state_nxt == S_VEND);
            coin_eject <= (state_nxt == S_EJECT);
            busy       <= (state != S_IDLE) || (count != '0);
            queue_full <= (count_nxt == CW'(FIFO_DEPTH));
            overflow   <= overflow | drop;
            fault      <= fault | (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// tb/tb_vend_payout_ctrl.sv - directed bench for vend_payout_ctrl with default parameters
module tb_vend_payout_ctrl;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       dispense = 1'b0;
    logic [1:0] change = 2'd0;
    logic       eject_ack = 1'b0;
    logic       vend_motor, coin_eject, busy, queue_full, overflow, fault;

    int n_cmp = 0;
    int n_bad = 0;

    vend_payout_ctrl dut (
        .clock      (clock),
        .rst        (rst),
        .dispense   (dispense),
        .change     (change),
        .eject_ack  (eject_ack),
        .vend_motor (vend_motor),
        .coin_eject (coin_eject),
        .busy       (busy),
        .queue_full (queue_full),
        .overflow   (overflow),
        .fault      (fault)
    );

    always #5 clock = ~clock;

    // Row k drives the inputs sampled at its edge; expected outputs are for the cycle after that edge.
    typedef struct {
        logic       rst;
        logic       dispense;
        logic [1:0] change;
        logic       ack;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [5:0] outs();
        return {vend_motor, coin_eject, busy, queue_full, overflow, fault};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic d, input logic [1:0] c, input logic a);
        dispense  = d;
        change    = c;
        eject_ack = a;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        cyc(1'b0, 2'd0, 1'b0);
        check(name, 32'(outs()), 32'd0);
        rst = 1'b0;
    endtask

    // One sale at edge 0; checks {vend, coin, busy, fault} every cycle against hand-derived windows.
    task automatic run_seq(input string name, input logic [1:0] ch, input int ack_e0, input int ack_e1,
                           input int ncyc, input int c0lo, input int c0hi, input int c1lo, input int c1hi,
                           input int busy_hi, input int fault_from);
        logic [3:0] exp;
        for (int k = 0; k < ncyc; k++) begin
            cyc(k == 0, ch, (k == ack_e0) || (k == ack_e1));
            exp[3] = (k >= 1) && (k <= 4);
            exp[2] = ((k >= c0lo) && (k <= c0hi)) || ((k >= c1lo) && (k <= c1hi));
            exp[1] = (k >= 1) && (k <= busy_hi);
            exp[0] = (k >= fault_from);
            check($sformatf("%s cyc%0d", name, k), 32'({vend_motor, coin_eject, busy, fault}), 32'(exp));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int served[$];
        int exp_served[5] = '{0, 1, 2, 3, 0};
        int coins_cnt, run;
        bit in_tx;
        logic pv, pc, ack_next;

        tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 6'b000000};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 6'b000000};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 6'b101000};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 6'b101000};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 1'b1, 6'b101000};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 6'b101000};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 6'b001000};
        tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, 6'b001000};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 6'b001000};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 6'b000000};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 6'b000000};

        // Single sale, no change; stray acks in VEND/GAP must be ignored.
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst;
            cyc(tbl[i].dispense, tbl[i].change, tbl[i].ack);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        do_reset("reset_a");
        run_seq("fifty", 2'd2, 9, 15, 24, 7, 10, 13, 16, 19, 9999);

        do_reset("reset_b");
        run_seq("late_ack", 2'd1, 21, -1, 28, 7, 10, -1, -1, 23, 9999);

        do_reset("reset_c");
        run_seq("no_ack", 2'd3, -1, -1, 80, 7, 10, -1, -1, 9999, 75);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 2'(i), 1'b0);
            check($sformatf("fault_push%0d", i), 32'(outs()),
                  32'({1'b0, 1'b0, 1'b1, (i >= 3), (i == 4), 1'b1}));
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 2'd0, 1'b1);
            check($sformatf("fault_hold%0d", i), 32'(outs()), 32'(6'b001111));
        end
        do_reset("reset_fault");

        // Overflow: 6 back-to-back sales, one dropped, the rest served in order with auto-acks.
        pv = 1'b0; pc = 1'b0; ack_next = 1'b0; run = 0; in_tx = 1'b0; coins_cnt = 0;
        for (int k = 0; k < 160; k++) begin
            cyc(k < 6, 2'(k), ack_next);
            ack_next = 1'b0;
            run = coin_eject ? run + 1 : 0;
            if (run == 2) ack_next = 1'b1;
            if (vend_motor && !pv) begin
                if (in_tx) served.push_back(coins_cnt);
                in_tx = 1'b1;
                coins_cnt = 0;
            end
            if (coin_eject && !pc) coins_cnt++;
            pv = vend_motor;
            pc = coin_eject;
            if (k == 3) check("ovf_qfull_c3", 32'({queue_full, overflow}), 32'(2'b00));
            if (k == 4) check("ovf_qfull_c4", 32'({queue_full, overflow}), 32'(2'b10));
            if (k == 5) check("ovf_flag_c5", 32'({queue_full, overflow}), 32'(2'b11));
        end
        if (in_tx) served.push_back(coins_cnt);
        check("ovf_served_n", 32'(served.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("ovf_order%0d", i), (i < served.size()) ? 32'(served[i]) : 32'hdead,
                  32'(exp_served[i]));
        check("ovf_final", 32'(outs()), 32'(6'b000010));

        // Reset during the 2nd coin of a 50c sale with two sales still queued.
        do_reset("reset_d");
        pc = 1'b0; ack_next = 1'b0; run = 0;
        for (int k = 0; k < 14; k++) begin
            cyc(k < 3, (k == 0) ? 2'd2 : (k == 1) ? 2'd1 : 2'd0, ack_next);
            ack_next = 1'b0;
            run = coin_eject ? run + 1 : 0;
            if (run == 2) ack_next = 1'b1;
        end
        check("mid_second_eject", 32'({coin_eject, busy, queue_full}), 32'(3'b110));
        rst = 1'b1;
        cyc(1'b0, 2'd0, 1'b0);
        check("mid_reset", 32'(outs()), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 2'd0, 1'b0);
            check($sformatf("mid_discard%0d", i), 32'(outs()), 32'd0);
        end
        run_seq("post_reset", 2'd0, -1, -1, 10, -1, -1, -1, -1, 7, 9999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
